// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : RV32I load/store width codes, FSM state encoding, access checks.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } lsu_state_t;

   // Unsigned widths exist only for loads; any store with funct3[2] set is illegal.
   function automatic logic access_err(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] offset);
      logic err;
      case (funct3)
         F3_B:    err = 1'b0;
         F3_H:    err = offset[0];
         F3_W:    err = (offset != 2'b00);
         F3_BU:   err = we;
         F3_HU:   err = we | offset[0];
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Byte-enable generation, store lane replication, load extraction.
// Revision : 1.0
// ============================================================================
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  we,
   input  logic [2:0]            funct3,
   input  logic [1:0]            offset,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [DATA_WIDTH-1:0] load_word,
   output logic [3:0]            be,
   output logic [DATA_WIDTH-1:0] lane_wdata,
   output logic [DATA_WIDTH-1:0] load_data
);

   logic [DATA_WIDTH-1:0] shifted;

   always_comb begin
      shifted    = load_word >> {offset, 3'b000};
      be         = 4'b1111;
      lane_wdata = store_data;
      load_data  = shifted;
      case (funct3)
         F3_B: begin
            if (we) be = 4'b0001 << offset;
            lane_wdata = {(DATA_WIDTH/8){store_data[7:0]}};
            load_data  = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         end
         F3_H: begin
            if (we) be = 4'b0011 << offset;
            lane_wdata = {(DATA_WIDTH/16){store_data[15:0]}};
            load_data  = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         end
         F3_BU: load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         F3_HU: load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding RV32I load/store unit with req/gnt memory port.
// Revision : 1.0
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   lsu_state_t            state;
   lsu_state_t            state_next;
   logic                  we_q;
   logic [2:0]            funct3_q;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic                  accept;
   logic                  req_err;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] lane_wdata;
   logic [DATA_WIDTH-1:0] load_data;

   assign req_ready = (state == S_IDLE);
   assign accept    = req_valid && req_ready;
   assign req_err   = access_err(req_we, req_funct3, req_addr[1:0]);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
         end
         if ((state == S_WAIT) && mem_rvalid) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (accept)     state_next = req_err ? S_RESP : S_REQ;
         S_REQ:  if (mem_gnt)    state_next = we_q ? S_RESP : S_WAIT;
         S_WAIT: if (mem_rvalid) state_next = S_RESP;
         S_RESP:                 state_next = S_IDLE;
         default:                state_next = S_IDLE;
      endcase
   end

   lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .we         (we_q),
      .funct3     (funct3_q),
      .offset     (addr_q[1:0]),
      .store_data (wdata_q),
      .load_word  (rdata_q),
      .be         (be),
      .lane_wdata (lane_wdata),
      .load_data  (load_data)
   );

   // Memory port is driven only while requesting so it stays quiet otherwise.
   assign mem_req   = (state == S_REQ);
   assign mem_we    = mem_req && we_q;
   assign mem_addr  = mem_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
   assign mem_be    = mem_req ? be : 4'b0000;
   assign mem_wdata = mem_req ? lane_wdata : '0;

   assign rsp_valid = (state == S_RESP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_req;
   logic        mem_gnt;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   load_store_unit #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .mem_req    (mem_req),
      .mem_gnt    (mem_gnt),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(negedge clk);
      check("req_ready_idle", req_ready, 1);
      next_cycle();
      req_valid  = 1'b0;
      req_we     = ~we;
      req_funct3 = 3'b111;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'h1357_9BDF;
   endtask

   task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp_addr, input logic [31:0] rdata,
                          input logic [31:0] exp_data);
      issue(1'b0, f3, addr, 32'h0);
      mem_gnt = 1'b1;
      @(negedge clk);
      check({tag, "_mem_req"},  mem_req, 1);
      check({tag, "_mem_we"},   mem_we, 0);
      check({tag, "_mem_addr"}, mem_addr, exp_addr);
      check({tag, "_mem_be"},   mem_be, 4'b1111);
      next_cycle();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      @(negedge clk);
      check({tag, "_rsp_early"}, rsp_valid, 0);
      next_cycle();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      @(negedge clk);
      check({tag, "_rsp_valid"}, rsp_valid, 1);
      check({tag, "_rsp_rdata"}, rsp_rdata, exp_data);
      check({tag, "_rsp_err"},   rsp_err, 0);
      next_cycle();
      @(negedge clk);
      check({tag, "_rsp_done"}, rsp_valid, 0);
      next_cycle();
   endtask

   task automatic store_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      issue(1'b1, f3, addr, wdata);
      mem_gnt = 1'b1;
      @(negedge clk);
      check({tag, "_mem_req"},   mem_req, 1);
      check({tag, "_mem_we"},    mem_we, 1);
      check({tag, "_mem_addr"},  mem_addr, exp_addr);
      check({tag, "_mem_be"},    mem_be, exp_be);
      check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
      next_cycle();
      mem_gnt = 1'b0;
      @(negedge clk);
      check({tag, "_rsp_valid"}, rsp_valid, 1);
      check({tag, "_rsp_err"},   rsp_err, 0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 0);
      next_cycle();
      @(negedge clk);
      check({tag, "_rsp_done"}, rsp_valid, 0);
      next_cycle();
   endtask

   task automatic err_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr);
      issue(we, f3, addr, 32'hA5A5_A5A5);
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h7777_7777;
      @(negedge clk);
      check({tag, "_mem_req"},   mem_req, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 1);
      check({tag, "_rsp_err"},   rsp_err, 1);
      check({tag, "_rsp_rdata"}, rsp_rdata, 0);
      next_cycle();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      @(negedge clk);
      check({tag, "_rsp_done"}, rsp_valid, 0);
      check({tag, "_ready"},    req_ready, 1);
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      repeat (3) next_cycle();
      @(negedge clk);
      check("rst_mem_req",   mem_req, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_mem_we",    mem_we, 0);
      check("rst_rsp_err",   rsp_err, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      next_cycle();

      // Stray read-valid pulses while idle
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_F00D;
      @(negedge clk);
      check("stray_rsp0", rsp_valid, 0);
      next_cycle();
      mem_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      check("stray_rsp1", rsp_valid, 0);
      check("stray_ready", req_ready, 1);
      next_cycle();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;

      // LHU with read data arriving one cycle late
      issue(1'b0, 3'b101, 32'h0000_0102, 32'h0);
      mem_gnt = 1'b1;
      @(negedge clk);
      check("lhu_mem_req",  mem_req, 1);
      check("lhu_mem_addr", mem_addr, 32'h0000_0100);
      check("lhu_mem_be",   mem_be, 4'b1111);
      next_cycle();
      mem_gnt = 1'b0;
      @(negedge clk);
      check("lhu_wait_req", mem_req, 0);
      check("lhu_wait_rsp", rsp_valid, 0);
      next_cycle();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h9ABC_5678;
      @(negedge clk);
      check("lhu_rsp_early", rsp_valid, 0);
      next_cycle();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      @(negedge clk);
      check("lhu_rsp_valid", rsp_valid, 1);
      check("lhu_rsp_rdata", rsp_rdata, 32'h0000_9ABC);
      check("lhu_rsp_err",   rsp_err, 0);
      next_cycle();

      load_op("lb",  3'b000, 32'h0000_0103, 32'h0000_0100, 32'h80FF_1234, 32'hFFFF_FF80);
      load_op("lh",  3'b001, 32'h0000_0100, 32'h0000_0100, 32'h1234_8001, 32'hFFFF_8001);
      load_op("lbu", 3'b100, 32'h0000_0101, 32'h0000_0100, 32'h0000_F700, 32'h0000_00F7);
      load_op("lw",  3'b010, 32'h0000_0104, 32'h0000_0104, 32'h89AB_CDEF, 32'h89AB_CDEF);

      store_op("sb", 3'b000, 32'h0000_0101, 32'h1234_565A, 32'h0000_0100, 4'b0010, 32'h5A5A_5A5A);
      store_op("sw", 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0000_0300, 4'b1111, 32'hDEAD_BEEF);

      // SH with grant held off for three cycles
      issue(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
      mem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("sh_stall_req",   mem_req, 1);
         check("sh_stall_we",    mem_we, 1);
         check("sh_stall_addr",  mem_addr, 32'h0000_0200);
         check("sh_stall_be",    mem_be, 4'b1100);
         check("sh_stall_wdata", mem_wdata, 32'hABCD_ABCD);
         check("sh_stall_rsp",   rsp_valid, 0);
         next_cycle();
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      check("sh_gnt_req",   mem_req, 1);
      check("sh_gnt_wdata", mem_wdata, 32'hABCD_ABCD);
      next_cycle();
      mem_gnt = 1'b0;
      @(negedge clk);
      check("sh_rsp_valid", rsp_valid, 1);
      check("sh_rsp_err",   rsp_err, 0);
      next_cycle();
      @(negedge clk);
      check("sh_rsp_done", rsp_valid, 0);
      next_cycle();

      err_op("lw_mis",  1'b0, 3'b010, 32'h0000_0006);
      err_op("f3_011",  1'b0, 3'b011, 32'h0000_0100);
      err_op("sh_mis",  1'b1, 3'b001, 32'h0000_0201);
      err_op("st_f3_4", 1'b1, 3'b100, 32'h0000_0100);

      // Reset while waiting for read data, then a late read-valid
      issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
      mem_gnt = 1'b1;
      next_cycle();
      mem_gnt = 1'b0;
      reset   = 1'b0;
      @(negedge clk);
      check("rw_wait_rsp", rsp_valid, 0);
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      check("rw_ready",   req_ready, 1);
      check("rw_rsp_rel", rsp_valid, 0);
      next_cycle();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1111_2222;
      @(negedge clk);
      check("rw_late_rsp",   rsp_valid, 0);
      check("rw_late_ready", req_ready, 1);
      next_cycle();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      @(negedge clk);
      check("rw_after_rsp", rsp_valid, 0);
      next_cycle();
      store_op("sw_post", 3'b010, 32'h0000_0300, 32'h0123_4567, 32'h0000_0300, 4'b1111, 32'h0123_4567);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data and address width in bits.
REQ-002 Ports, in this order; the unit has one clock, and reset is synchronous and active-low:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  execute stage presents a memory operation
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr  in  DATA_WIDTH  effective byte address, the ALUResult of the execute stage
- req_wdata  in  DATA_WIDTH  store data (rs2)
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepts the request this cycle
- mem_we  out  1  write enable
- mem_addr  out  DATA_WIDTH  word address; bits [1:0] are always 00
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_WIDTH  lane-aligned store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read word
- rsp_valid  out  1  single-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors
- rsp_err  out  1  misaligned access or illegal funct3

Function
REQ-003 FSM states: IDLE, REQ, WAIT, RESP. req_ready SHALL be 1 only in IDLE.
REQ-004 A request is accepted when req_valid && req_ready. On acceptance the unit SHALL register we, funct3, addr and wdata. Later changes on req_* SHALL be ignored until the unit returns to IDLE.
REQ-005 Error check on acceptance:
- halfword access with addr[0]=1 is an error
- word access with addr[1:0]!=00 is an error
- funct3 of 011, 110 or 111 is an error, and so is funct3 1xx on a store
- On any error: IDLE->RESP, mem_req is never asserted, rsp_err=1, rsp_rdata=0.
REQ-006 Normal path: IDLE->REQ. In REQ, mem_req=1 and the memory outputs SHALL stay stable until mem_gnt=1.
REQ-007 On mem_gnt=1: a store goes REQ->RESP; a load goes REQ->WAIT.
REQ-008 In WAIT the unit holds until mem_rvalid=1, then captures mem_rdata and goes to RESP. mem_rvalid SHALL be ignored in IDLE, REQ and RESP.
REQ-009 RESP lasts exactly one cycle with rsp_valid=1, then returns to IDLE. There is no response backpressure.
REQ-010 Latency: with acceptance in cycle N and mem_gnt in the same cycle as the first mem_req, mem_req is asserted in N+1. A store gives rsp_valid in N+2. A load with mem_rvalid in N+2 gives rsp_valid in N+3. An error gives rsp_valid in N+1.
REQ-011 Byte enables, with o = addr[1:0]:
- SB: mem_be = 0001 << o
- SH: mem_be = 0011 << o
- SW: mem_be = 1111
- Loads: mem_be = 1111
REQ-012 Store data: SB replicates wdata[7:0] into all four lanes; SH replicates wdata[15:0] into both halves; SW passes wdata through.
REQ-013 Load data: shift rdata right by 8*o, then:
- LB/LH sign-extend bit 7/15
- LBU/LHU zero-extend
- LW passes the word through
REQ-014 Outside REQ, mem_req and mem_we SHALL be 0. Outside RESP, rsp_valid, rsp_err and rsp_rdata SHALL be 0.

Reset
REQ-015 When reset=0 at a rising clk edge: state=IDLE and every registered output is 0. Combinationally, req_ready=1 once reset is deasserted.
REQ-016 Reset in any state SHALL abandon the operation. No rsp_valid is produced for it, and a late mem_rvalid arriving afterwards SHALL be ignored.

Structure
REQ-017 Package lsu_pkg SHALL hold the funct3 width codes as named constants and the FSM state enum; the module imports it.
REQ-018 One combinational sub-module, lsu_align, SHALL implement the byte-enable, store-replication and load-extraction/extension logic (REQ-011 to REQ-013). load_store_unit holds the FSM and registers.

Verification
REQ-019 LB from addr 0x103 with mem_rdata 0x80FF_1234 -> mem_addr 0x100, mem_be 1111, rsp_rdata 0xFFFF_FF80, rsp_valid at N+3 (REQ-010 timing).
REQ-020 SH to addr 0x202 with wdata 0x0000_ABCD, mem_gnt delayed 3 cycles -> mem_addr 0x200, mem_be 1100, mem_wdata 0xABCD_ABCD, all memory outputs held stable through the stall, rsp_valid 1 cycle after gnt.
REQ-021 LW from addr 0x006 -> no mem_req, rsp_valid at N+1 with rsp_err=1, rsp_rdata=0. funct3=011 -> same response.
REQ-022 LHU from addr 0x102 with mem_rdata 0x9ABC_5678 -> rsp_rdata 0x0000_9ABC. Stray mem_rvalid pulses in IDLE before the request -> no effect.
REQ-023 Reset asserted in WAIT, then mem_rvalid=1 one cycle after release -> no rsp_valid, req_ready=1, and a following SW completes normally.
